axi4_reg_slice: RTL

- Full five-channel AXI4 register slice placed directly upstream of the memory-mapped AXI4 slave, between the NPU interconnect and the slave's s_axi port.
- Breaks every combinational path (valid, ready, payload) on AW, W, B, AR and R using a two-entry skid buffer per channel.
- Sustains one beat per cycle per channel with one cycle of forward latency.
- Transparent to protocol: no reordering, no payload modification, no burst interpretation.

---
 rtl/axi4_reg_slice.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_reg_slice.sv
// Five-channel AXI4 register slice: a two-entry skid buffer per channel breaks every valid/ready/payload path.
// Optional performance counters are enabled by defining AXI4_REG_SLICE_PERF_EN.

module axi4_reg_slice_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             push;
    logic             pop;

    assign push      = in_valid && in_ready_q;
    assign pop       = (state_q != EMPTY) && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (push && pop) begin
                    main_d  = in_data;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // Input ready is low here, so only a pop can move the state.
                if (pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != FULL);
        end
    end

endmodule

module axi4_reg_slice #(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ADDR_WIDTH = 40,
    parameter int AXI_ID_WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef AXI4_REG_SLICE_PERF_EN
    input  logic                        perf_clr,
    output logic [31:0]                 perf_aw_cnt,
    output logic [31:0]                 perf_ar_cnt,
    output logic [31:0]                 perf_w_stall,
    output logic [31:0]                 perf_r_stall,
`endif
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);

    localparam int A_W = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 8 + 3 + 2;
    localparam int W_W = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 1;
    localparam int B_W = AXI_ID_WIDTH + 2;
    localparam int R_W = AXI_ID_WIDTH + AXI_DATA_WIDTH + 2 + 1;

    logic [A_W-1:0] aw_out;
    logic [W_W-1:0] w_out;
    logic [B_W-1:0] b_out;
    logic [A_W-1:0] ar_out;
    logic [R_W-1:0] r_out;

    axi4_reg_slice_skid #(.WIDTH(A_W)) u_aw (
        .clk(clk), .rst(rst),
        .in_valid(s_axi_awvalid), .in_ready(s_axi_awready),
        .in_data({s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst}),
        .out_valid(m_axi_awvalid), .out_ready(m_axi_awready), .out_data(aw_out)
    );
    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst} = aw_out;

    axi4_reg_slice_skid #(.WIDTH(W_W)) u_w (
        .clk(clk), .rst(rst),
        .in_valid(s_axi_wvalid), .in_ready(s_axi_wready),
        .in_data({s_axi_wdata, s_axi_wstrb, s_axi_wlast}),
        .out_valid(m_axi_wvalid), .out_ready(m_axi_wready), .out_data(w_out)
    );
    assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_out;

    // Response channels run slave-to-master, so the m side feeds the buffer.
    axi4_reg_slice_skid #(.WIDTH(B_W)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(m_axi_bvalid), .in_ready(m_axi_bready),
        .in_data({m_axi_bid, m_axi_bresp}),
        .out_valid(s_axi_bvalid), .out_ready(s_axi_bready), .out_data(b_out)
    );
    assign {s_axi_bid, s_axi_bresp} = b_out;

    axi4_reg_slice_skid #(.WIDTH(A_W)) u_ar (
        .clk(clk), .rst(rst),
        .in_valid(s_axi_arvalid), .in_ready(s_axi_arready),
        .in_data({s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst}),
        .out_valid(m_axi_arvalid), .out_ready(m_axi_arready), .out_data(ar_out)
    );
    assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst} = ar_out;

    axi4_reg_slice_skid #(.WIDTH(R_W)) u_r (
        .clk(clk), .rst(rst),
        .in_valid(m_axi_rvalid), .in_ready(m_axi_rready),
        .in_data({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast}),
        .out_valid(s_axi_rvalid), .out_ready(s_axi_rready), .out_data(r_out)
    );
    assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = r_out;

`ifdef AXI4_REG_SLICE_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
        return (en && cnt != 32'hFFFF_FFFF) ? cnt + 32'd1 : cnt;
    endfunction

    // Clear (reset or perf_clr) wins over any increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            perf_aw_cnt  <= '0;
            perf_ar_cnt  <= '0;
            perf_w_stall <= '0;
            perf_r_stall <= '0;
        end else begin
            perf_aw_cnt  <= sat_inc(perf_aw_cnt, s_axi_awvalid && s_axi_awready);
            perf_ar_cnt  <= sat_inc(perf_ar_cnt, s_axi_arvalid && s_axi_arready);
            perf_w_stall <= sat_inc(perf_w_stall, m_axi_wvalid && !m_axi_wready);
            perf_r_stall <= sat_inc(perf_r_stall, s_axi_rvalid && !s_axi_rready);
        end
    end
`endif

endmodule
